// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared SPI definitions used by the master transmitter and the slave
// receiver: FSM state encodings, word width, bus mode constants and a small
// elaboration-time helper.
// No ports (package).
// ---------------------------------------------------------------------------
package spi_pkg;

    localparam int SPI_WORD_W = 8;

    // Mode 0: sck idles low, data sampled on the rising edge.
    localparam bit SPI_CPOL = 1'b0;
    localparam bit SPI_CPHA = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_LOW   = 3'd2,
        ST_HIGH  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } spi_state_e;

    function automatic int spi_max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// ---------------------------------------------------------------------------
// spi_phase_timer
// Loadable down-counter shared by every timed phase of the SPI master.
// Loading N-1 on phase entry makes o_tc assert in the N-th cycle of the phase.
// Ports:
//   i_clk       system clock
//   i_reset     synchronous active-high reset
//   i_load      load i_load_val this cycle (phase entry)
//   i_load_val  phase length minus one
//   o_tc        count is zero: last cycle of the current phase
//   o_tc_next   count is one: the next cycle is the last of the phase
// ---------------------------------------------------------------------------
module spi_phase_timer #(
    parameter int W = 3
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_tc,
    output logic         o_tc_next
);

    logic [W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tc      = (r_cnt == '0);
    assign o_tc_next = (r_cnt == W'(1));

endmodule

// File: rtl/spi_master_tx.sv
// ---------------------------------------------------------------------------
// spi_master_tx
// SPI mode-0 master transmitter, MSB first, 8-bit frames. Bytes arrive over a
// valid/ready handshake and are shifted out at clk/(2*CLK_DIV). Every frame
// ends with an sck-low HOLD phase while cs is still low so the receiver can
// register its last bit.
// Build option: define SPI_MASTER_TX_BURST_EN to accept one follow-on byte
// during HOLD and continue without releasing cs.
// Ports:
//   i_clk       system clock
//   i_reset     synchronous active-high reset (aborts any frame at once)
//   i_tx_data   byte to send, sampled on accept
//   i_tx_valid  byte available
//   o_tx_ready  block can accept (accept = i_tx_valid & o_tx_ready)
//   o_busy      high in every state except IDLE
//   o_done      one-cycle pulse in the last cycle of each byte's HOLD phase
//   o_sck       serial clock, idles low
//   o_mosi      serial data, changes only while sck is low
//   o_cs        chip select, active low
// ---------------------------------------------------------------------------
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_GAP   = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [SPI_WORD_W-1:0] i_tx_data,
    input  logic                  i_tx_valid,
    output logic                  o_tx_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_sck,
    output logic                  o_mosi,
    output logic                  o_cs
);

    localparam int DIV_W = $clog2(spi_max3(CLK_DIV, CS_SETUP, CS_GAP) + 1);

    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("spi_master_tx: CLK_DIV must be >= 2");
    end
    if (CS_SETUP < 1) begin : g_bad_cs_setup
        $error("spi_master_tx: CS_SETUP must be >= 1");
    end
    if (CS_GAP < 1) begin : g_bad_cs_gap
        $error("spi_master_tx: CS_GAP must be >= 1");
    end

    spi_state_e            r_state, w_next_state;
    logic [SPI_WORD_W-1:0] r_shreg;
    logic [2:0]            r_bitcnt;
    logic                  r_tx_ready, r_busy, r_done, r_sck, r_mosi, r_cs;
    logic                  w_tx_ready_d, w_busy_d, w_done_d, w_sck_d, w_cs_d;
    logic                  w_load, w_tc, w_tc_next;
    logic [DIV_W-1:0]      w_load_val;
    logic                  w_accept, w_have_next, w_pending_d;

    assign w_accept = i_tx_valid & r_tx_ready;

`ifdef SPI_MASTER_TX_BURST_EN
    logic                  r_pending;
    logic [SPI_WORD_W-1:0] r_pend_data;
    logic [SPI_WORD_W-1:0] w_next_byte;

    // A byte accepted in the final HOLD cycle is used directly; earlier ones
    // wait in the pending register.
    assign w_have_next = r_pending | w_accept;
    assign w_next_byte = r_pending ? r_pend_data : i_tx_data;
    assign w_pending_d = (r_state == ST_HOLD) && !w_tc && w_have_next;
`else
    assign w_have_next = 1'b0;
    assign w_pending_d = 1'b0;
`endif

    spi_phase_timer #(.W(DIV_W)) u_timer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_tc       (w_tc),
        .o_tc_next  (w_tc_next)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next_state;
    end

    // Next-state logic.
    // NOTE: every variable written here gets a default first so no latch is
    // inferred on paths that do not assign it.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_accept) w_next_state = ST_SETUP;
            ST_SETUP: if (w_tc)     w_next_state = ST_LOW;
            ST_LOW:   if (w_tc)     w_next_state = ST_HIGH;
            ST_HIGH:  if (w_tc)     w_next_state = (r_bitcnt == 3'd7) ? ST_HOLD : ST_LOW;
            ST_HOLD:  if (w_tc)     w_next_state = w_have_next ? ST_LOW : ST_GAP;
            ST_GAP:   if (w_tc)     w_next_state = ST_IDLE;
            default:                w_next_state = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs plus timer reload.
    // Outputs follow the state being entered, so they line up with it.
    always_comb begin
        w_load     = (w_next_state != r_state);
        w_load_val = '0;
        case (w_next_state)
            ST_SETUP:                  w_load_val = DIV_W'(CS_SETUP - 1);
            ST_LOW, ST_HIGH, ST_HOLD:  w_load_val = DIV_W'(CLK_DIV - 1);
            ST_GAP:                    w_load_val = DIV_W'(CS_GAP - 1);
            default:                   w_load_val = '0;
        endcase
        w_cs_d       = (w_next_state == ST_IDLE) || (w_next_state == ST_GAP);
        w_sck_d      = (w_next_state == ST_HIGH);
        w_busy_d     = (w_next_state != ST_IDLE);
        w_done_d     = (r_state == ST_HOLD) && w_tc_next;
        w_tx_ready_d = (w_next_state == ST_IDLE);
`ifdef SPI_MASTER_TX_BURST_EN
        // Ready drops as soon as the single follow-on slot is taken.
        if (w_next_state == ST_HOLD && !w_pending_d) w_tx_ready_d = 1'b1;
`endif
    end

    // Output registers and datapath.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cs       <= 1'b1;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_tx_ready <= 1'b0;
            r_bitcnt   <= '0;
            r_shreg    <= '0;
`ifdef SPI_MASTER_TX_BURST_EN
            r_pending   <= 1'b0;
            r_pend_data <= '0;
`endif
        end else begin
            r_cs       <= w_cs_d;
            r_sck      <= w_sck_d;
            r_done     <= w_done_d;
            r_busy     <= w_busy_d;
            r_tx_ready <= w_tx_ready_d;
            if (r_state == ST_IDLE && w_accept) begin
                r_shreg  <= i_tx_data;
                r_mosi   <= i_tx_data[SPI_WORD_W-1];
                r_bitcnt <= '0;
            end else if (r_state == ST_HIGH && w_tc && r_bitcnt != 3'd7) begin
                // mosi moves on the falling sck edge, a full half-period
                // before the next rising edge.
                r_shreg  <= {r_shreg[SPI_WORD_W-2:0], 1'b0};
                r_mosi   <= r_shreg[SPI_WORD_W-2];
                r_bitcnt <= r_bitcnt + 3'd1;
            end
`ifdef SPI_MASTER_TX_BURST_EN
            else if (r_state == ST_HOLD && w_tc && w_have_next) begin
                r_shreg  <= w_next_byte;
                r_mosi   <= w_next_byte[SPI_WORD_W-1];
                r_bitcnt <= '0;
            end
            r_pending <= w_pending_d;
            if (r_state == ST_HOLD && w_accept) r_pend_data <= i_tx_data;
`endif
        end
    end

    assign o_tx_ready = r_tx_ready;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_sck      = r_sck;
    assign o_mosi     = r_mosi;
    assign o_cs       = r_cs;

endmodule

// File: tb/tb_spi_master_tx.sv
// ---------------------------------------------------------------------------
// tb_spi_master_tx
// Self-checking bench for spi_master_tx. Channel 0 runs CLK_DIV=4,
// CS_SETUP=2, CS_GAP=2; channel 1 runs CLK_DIV=2, CS_SETUP=1, CS_GAP=1.
// A passive mode-0 receiver model per channel rebuilds bytes from mosi at
// each sck rise and records cs/sck timing in clock-edge numbers.
// ---------------------------------------------------------------------------
module tb_spi_master_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] tx_valid = '0;
    logic [7:0] tx_data [2];
    wire  [1:0] tx_ready, busy, done, sck, mosi, cs;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_master_tx #(.CLK_DIV(4), .CS_SETUP(2), .CS_GAP(2)) u_dut0 (
        .i_clk(clk), .i_reset(rst), .i_tx_data(tx_data[0]), .i_tx_valid(tx_valid[0]),
        .o_tx_ready(tx_ready[0]), .o_busy(busy[0]), .o_done(done[0]),
        .o_sck(sck[0]), .o_mosi(mosi[0]), .o_cs(cs[0])
    );

    spi_master_tx #(.CLK_DIV(2), .CS_SETUP(1), .CS_GAP(1)) u_dut1 (
        .i_clk(clk), .i_reset(rst), .i_tx_data(tx_data[1]), .i_tx_valid(tx_valid[1]),
        .o_tx_ready(tx_ready[1]), .o_busy(busy[1]), .o_done(done[1]),
        .o_sck(sck[1]), .o_mosi(mosi[1]), .o_cs(cs[1])
    );

    // ---------------- receiver model / monitor ----------------
    logic [7:0] sh [2];
    int  rx_q[$];                       // entries are ch*256 + byte
    bit  prev_cs [2] = '{1'b1, 1'b1};
    bit  prev_sck [2], prev_mosi [2], in_win [2];
    int  nbit [2], win_rises [2], last_win_rises [2], win_cnt [2];
    int  done_cnt [2], mosi_viol [2], rise_period [2], last_rise_e [2];
    int  cs_fall_e [2], first_rise_e [2];
    int  cs_rise_e [2] = '{-1, -1};
    int  min_gap [2]   = '{1000000, 1000000};

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                in_win[k]    = 1'b0;
                win_rises[k] = 0;
                nbit[k]      = 0;
            end else begin
                if (done[k]) done_cnt[k]++;
                if (!cs[k] && prev_cs[k]) begin
                    in_win[k]    = 1'b1;
                    win_rises[k] = 0;
                    nbit[k]      = 0;
                    cs_fall_e[k] = cyc;
                    if (cs_rise_e[k] >= 0 && cyc - cs_rise_e[k] < min_gap[k])
                        min_gap[k] = cyc - cs_rise_e[k];
                end
                if (sck[k] && !prev_sck[k]) begin
                    if (win_rises[k] == 0) first_rise_e[k] = cyc;
                    else                   rise_period[k]  = cyc - last_rise_e[k];
                    last_rise_e[k] = cyc;
                    win_rises[k]++;
                    sh[k] = {sh[k][6:0], mosi[k]};
                    nbit[k]++;
                    if (nbit[k] == 8) begin
                        rx_q.push_back(k * 256 + int'(sh[k]));
                        nbit[k] = 0;
                    end
                end
                if (sck[k] && (mosi[k] != prev_mosi[k])) mosi_viol[k]++;
                if (cs[k] && !prev_cs[k] && in_win[k]) begin
                    in_win[k]         = 1'b0;
                    last_win_rises[k] = win_rises[k];
                    win_cnt[k]++;
                    cs_rise_e[k]      = cyc;
                end
            end
            prev_cs[k]   = cs[k];
            prev_sck[k]  = sck[k];
            prev_mosi[k] = mosi[k];
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Step to just after the falling edge; the monitor has already run.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int pop_rx();
        if (rx_q.size() == 0) return -1;
        return rx_q.pop_front();
    endfunction

    // Offer one byte, return the clock-edge number at which it was accepted.
    task automatic send(input int ch, input logic [7:0] d, output int acc_e);
        int n = 0;
        while (!tx_ready[ch] && n < 300) begin
            tick();
            n++;
        end
        check("send_ready", 32'(tx_ready[ch]), 1);
        tx_valid[ch] = 1'b1;
        tx_data[ch]  = d;
        acc_e        = cyc + 1;
        tick();
        tx_valid[ch] = 1'b0;
        tx_data[ch]  = ~d;              // data may change freely after accept
    endtask

    task automatic wait_win(input int ch, input int target);
        int n = 0;
        while (win_cnt[ch] < target && n < 600) begin
            tick();
            n++;
        end
    endtask

    typedef struct {
        int         ch;
        logic [7:0] data;
        int         rise_lat;   // accept edge to first sck rise
        int         len;        // accept edge to cs rise
        int         period;     // sck rise-to-rise
    } vec_t;

    vec_t vecs [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc, w0, d0, n;
        tx_data[0] = 8'h00;
        tx_data[1] = 8'h00;

        vecs[0] = '{0, 8'hA5, 6, 70, 8};
        vecs[1] = '{0, 8'h00, 6, 70, 8};
        vecs[2] = '{0, 8'hFF, 6, 70, 8};
        vecs[3] = '{1, 8'h81, 3, 35, 4};
        vecs[4] = '{1, 8'h7E, 3, 35, 4};
        vecs[5] = '{0, 8'h5A, 6, 70, 8};

        // Reset state.
        repeat (3) tick();
        check("reset_outs0", 32'({cs[0], sck[0], mosi[0], done[0], busy[0], tx_ready[0]}), 32'b100000);
        check("reset_outs1", 32'({cs[1], sck[1], mosi[1], done[1], busy[1], tx_ready[1]}), 32'b100000);
        rst = 1'b0;
        tick();
        check("ready_after_reset", 32'(tx_ready), 32'b11);
        check("idle_busy", 32'(busy), 0);

        // Table-driven single frames.
        foreach (vecs[i]) begin
            int ch;
            ch = vecs[i].ch;
            w0 = win_cnt[ch];
            d0 = done_cnt[ch];
            send(ch, vecs[i].data, acc);
            wait_win(ch, w0 + 1);
            check($sformatf("v%0d_frames", i),     32'(win_cnt[ch] - w0), 1);
            check($sformatf("v%0d_byte", i),       32'(pop_rx()), 32'(ch * 256 + int'(vecs[i].data)));
            check($sformatf("v%0d_rises", i),      32'(last_win_rises[ch]), 8);
            check($sformatf("v%0d_cs_fall", i),    32'(cs_fall_e[ch] - acc), 0);
            check($sformatf("v%0d_first_rise", i), 32'(first_rise_e[ch] - acc), 32'(vecs[i].rise_lat));
            check($sformatf("v%0d_cs_rise", i),    32'(cs_rise_e[ch] - acc), 32'(vecs[i].len));
            check($sformatf("v%0d_done", i),       32'(done_cnt[ch] - d0), 1);
            check($sformatf("v%0d_period", i),     32'(rise_period[ch]), 32'(vecs[i].period));
        end

        // Reset mid-frame after the 4th sck rise: abort with no done pulse.
        w0 = win_cnt[0];
        d0 = done_cnt[0];
        send(0, 8'hF0, acc);
        n = 0;
        while (win_rises[0] < 4 && n < 300) begin
            tick();
            n++;
        end
        check("abort_rises", 32'(win_rises[0]), 4);
        rst = 1'b1;
        tick();
        check("abort_outs", 32'({cs[0], sck[0], mosi[0], done[0], busy[0], tx_ready[0]}), 32'b100000);
        rst = 1'b0;
        tick();
        check("abort_ready", 32'(tx_ready[0]), 1);
        repeat (20) tick();
        check("abort_no_done", 32'(done_cnt[0] - d0), 0);
        check("abort_no_frame", 32'(win_cnt[0] - w0), 0);
        check("abort_no_byte", 32'(rx_q.size()), 0);
        send(0, 8'h5A, acc);
        wait_win(0, w0 + 1);
        check("post_abort_byte", 32'(pop_rx()), 32'h5A);
        check("post_abort_len", 32'(cs_rise_e[0] - acc), 70);

        // tx_valid while busy is ignored; data changed after accept is ignored.
        w0 = win_cnt[0];
        send(0, 8'h96, acc);
        repeat (10) tick();
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'h11;
        tick();
        tx_valid[0] = 1'b0;
        wait_win(0, w0 + 1);
        check("busy_ignore_byte", 32'(pop_rx()), 32'h96);
        repeat (150) tick();
        check("busy_ignore_frames", 32'(win_cnt[0] - w0), 1);
        check("busy_ignore_extra", 32'(rx_q.size()), 0);

        // tx_valid held across two bytes.
        w0 = win_cnt[0];
        d0 = done_cnt[0];
        n  = 0;
        while (!tx_ready[0] && n < 300) begin
            tick();
            n++;
        end
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'h3C;
        tick();
        tx_data[0]  = 8'hC3;
        n = 0;
        while (!tx_ready[0] && n < 300) begin
            tick();
            n++;
        end
        check("two_ready2", 32'(tx_ready[0]), 1);
        tick();
        tx_valid[0] = 1'b0;
`ifdef SPI_MASTER_TX_BURST_EN
        wait_win(0, w0 + 1);
        check("two_windows", 32'(win_cnt[0] - w0), 1);
        check("two_rises", 32'(last_win_rises[0]), 16);
`else
        wait_win(0, w0 + 2);
        check("two_windows", 32'(win_cnt[0] - w0), 2);
        check("two_rises", 32'(last_win_rises[0]), 8);
`endif
        check("two_done", 32'(done_cnt[0] - d0), 2);
        check("two_byte0", 32'(pop_rx()), 32'h3C);
        check("two_byte1", 32'(pop_rx()), 32'hC3);

        // Whole-run properties.
        check("mosi_stable0", 32'(mosi_viol[0]), 0);
        check("mosi_stable1", 32'(mosi_viol[1]), 0);
        check("cs_gap0", 32'(min_gap[0] >= 2), 1);
        check("cs_gap1", 32'(min_gap[1] >= 1), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
